// File: rtl/fwrisc_exec_pkg.sv
// fwrisc_exec_pkg
// Shared types for the fwrisc execute stage.
//   - op_type_e  : operation class driven on op_type
//   - alu_op_e, br_op_e, shift_op_e : sub-operation encodings carried on op
//   - state_e    : execute-stage FSM states
//   - XLEN_DEFAULT / RADDR_W_DEFAULT : default datapath and register-address widths
package fwrisc_exec_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int RADDR_W_DEFAULT = 6;

  typedef enum logic [4:0] {
    OPT_ALU    = 5'd0,
    OPT_SHIFT  = 5'd1,
    OPT_BRANCH = 5'd2,
    OPT_JUMP   = 5'd3,
    OPT_LDST   = 5'd4
  } op_type_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_PASSB = 4'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_EQ  = 4'd0,
    BR_NE  = 4'd1,
    BR_LT  = 4'd2,
    BR_GE  = 4'd3,
    BR_LTU = 4'd4,
    BR_GEU = 4'd5
  } br_op_e;

  typedef enum logic [3:0] {
    SH_SLL = 4'd0,
    SH_SRL = 4'd1,
    SH_SRA = 4'd2
  } shift_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/fwrisc_exec_if.sv
// fwrisc_exec_if
// Bundle between the decode/execute pipeline register, the execute stage and
// the memory/writeback register.
//   master : pipeline side - drives the decoded instruction, sees stall and results
//   slave  : execute stage - consumes the instruction, drives stall and results
interface fwrisc_exec_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 6
);
  // Decoded instruction from the pipeline register
  logic               in_valid;
  logic               instr_c;
  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic [XLEN-1:0]    op_c;
  logic [3:0]         op;
  logic [4:0]         op_type;
  logic [RADDR_W-1:0] rd_waddr;
  // Back-pressure to the hazard logic
  logic               stall;
  // Registered result bundle
  logic               out_valid;
  logic [4:0]         out_op_type;
  logic [RADDR_W-1:0] out_rd_waddr;
  logic               out_wen;
  logic [XLEN-1:0]    out_result;
  logic [XLEN-1:0]    out_store_data;
  logic               branch_taken;
  logic [XLEN-1:0]    branch_target;

  modport master (
    output in_valid, instr_c, op_a, op_b, op_c, op, op_type, rd_waddr,
    input  stall, out_valid, out_op_type, out_rd_waddr, out_wen,
           out_result, out_store_data, branch_taken, branch_target
  );

  modport slave (
    input  in_valid, instr_c, op_a, op_b, op_c, op, op_type, rd_waddr,
    output stall, out_valid, out_op_type, out_rd_waddr, out_wen,
           out_result, out_store_data, branch_taken, branch_target
  );
endinterface

// File: rtl/fwrisc_exec_shifter.sv
// fwrisc_exec_shifter
// Shift unit of the execute stage. Build option: FWRISC_EXEC_FAST_SHIFT_EN.
//   Default   : iterative shifter. load captures data_in/amount/shift_op; each
//               step cycle shifts one bit and decrements the counter. result is
//               the value after the current step, last flags the final step.
//   Macro set : single-cycle barrel shifter; result = data_in shifted by amount,
//               last is unused (tied 0).
// Ports: clock, reset (reset or flush), load, step, shift_op, data_in, amount,
//        result, last.
module fwrisc_exec_shifter
  import fwrisc_exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [3:0]      shift_op,
  input  logic [XLEN-1:0] data_in,
  input  logic [4:0]      amount,
  output logic [XLEN-1:0] result,
  output logic            last
);

`ifdef FWRISC_EXEC_FAST_SHIFT_EN

  always_comb begin
    result = data_in;
    case (shift_op_e'(shift_op))
      SH_SLL:  result = data_in << amount;
      SH_SRL:  result = data_in >> amount;
      SH_SRA:  result = XLEN'($signed(data_in) >>> amount);
      default: result = data_in;
    endcase
  end

  assign last = 1'b0;

`else

  logic [XLEN-1:0] shreg_reg;
  logic [4:0]      cnt_reg;
  shift_op_e       op_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      op_reg    <= SH_SLL;
    end else if (load) begin
      shreg_reg <= data_in;
      cnt_reg   <= amount;
      op_reg    <= shift_op_e'(shift_op);
    end else if (step && (cnt_reg != 5'd0)) begin
      shreg_reg <= result;
      cnt_reg   <= cnt_reg - 5'd1;
    end
  end

  // One-bit shift of the current register contents; SRA replicates bit XLEN-1.
  always_comb begin
    result = shreg_reg;
    case (op_reg)
      SH_SLL:  result = {shreg_reg[XLEN-2:0], 1'b0};
      SH_SRL:  result = {1'b0, shreg_reg[XLEN-1:1]};
      SH_SRA:  result = {shreg_reg[XLEN-1], shreg_reg[XLEN-1:1]};
      default: result = shreg_reg;
    endcase
  end

  assign last = (cnt_reg == 5'd1);

`endif

endmodule

// File: rtl/fwrisc_exec_stage.sv
// fwrisc_exec_stage
// Execute stage of the pipelined fwrisc core: ALU, branch/jump resolution,
// load/store address generation and shifts, with a registered result bundle.
// Build option: FWRISC_EXEC_FAST_SHIFT_EN selects a barrel shifter (no SHIFT
// state, stall always 0); undefined selects the one-bit-per-cycle shifter.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   flush        : synchronous discard of the in-flight instruction (acts as reset)
//   bus          : fwrisc_exec_if.slave - instruction in, stall, result bundle out
module fwrisc_exec_stage
  import fwrisc_exec_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  fwrisc_exec_if.slave bus
);

  logic clear;
  assign clear = reset | flush;

  state_e state_reg, state_next;

  logic               out_valid_reg,      out_valid_next;
  logic [4:0]         out_op_type_reg,    out_op_type_next;
  logic [RADDR_W-1:0] out_rd_waddr_reg,   out_rd_waddr_next;
  logic               out_wen_reg,        out_wen_next;
  logic [XLEN-1:0]    out_result_reg,     out_result_next;
  logic [XLEN-1:0]    out_store_data_reg, out_store_data_next;
  logic               branch_taken_reg,   branch_taken_next;
  logic [XLEN-1:0]    branch_target_reg,  branch_target_next;

  logic [XLEN-1:0]    alu_result;
  logic               br_cond;
  logic [XLEN-1:0]    sh_result;
  logic               sh_last;
  logic               sh_load;
  logic               sh_step;
  logic [4:0]         sh_amount;
  logic               accept;
  logic               rd_nonzero;

  assign sh_amount  = bus.op_b[4:0];
  assign accept     = (state_reg == ST_IDLE) && bus.in_valid;
  assign rd_nonzero = (bus.rd_waddr != '0);

  // ALU datapath
  always_comb begin
    alu_result = '0;
    case (alu_op_e'(bus.op))
      ALU_ADD:   alu_result = bus.op_a + bus.op_b;
      ALU_SUB:   alu_result = bus.op_a - bus.op_b;
      ALU_AND:   alu_result = bus.op_a & bus.op_b;
      ALU_OR:    alu_result = bus.op_a | bus.op_b;
      ALU_XOR:   alu_result = bus.op_a ^ bus.op_b;
      ALU_SLT:   alu_result = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_SLTU:  alu_result = XLEN'(bus.op_a < bus.op_b);
      ALU_PASSB: alu_result = bus.op_b;
      default:   alu_result = '0;
    endcase
  end

  // Branch condition
  always_comb begin
    br_cond = 1'b0;
    case (br_op_e'(bus.op))
      BR_EQ:   br_cond = (bus.op_a == bus.op_b);
      BR_NE:   br_cond = (bus.op_a != bus.op_b);
      BR_LT:   br_cond = ($signed(bus.op_a) < $signed(bus.op_b));
      BR_GE:   br_cond = ($signed(bus.op_a) >= $signed(bus.op_b));
      BR_LTU:  br_cond = (bus.op_a < bus.op_b);
      BR_GEU:  br_cond = (bus.op_a >= bus.op_b);
      default: br_cond = 1'b0;
    endcase
  end

  fwrisc_exec_shifter #(
    .XLEN(XLEN)
  ) u_shifter (
    .clock    (clock),
    .reset    (clear),
    .load     (sh_load),
    .step     (sh_step),
    .shift_op (bus.op),
    .data_in  (bus.op_a),
    .amount   (sh_amount),
    .result   (sh_result),
    .last     (sh_last)
  );

`ifndef FWRISC_EXEC_FAST_SHIFT_EN
  // Destination of the shift in progress; upstream holds its inputs, but the
  // result bundle is built from captured state so it cannot drift.
  logic [RADDR_W-1:0] pend_rd_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      pend_rd_reg <= '0;
    end else if (sh_load) begin
      pend_rd_reg <= bus.rd_waddr;
    end
  end
`endif

  // Next-state and result-bundle logic. Data outputs hold by default; the
  // qualifier flags are single-cycle pulses.
  always_comb begin
    state_next          = state_reg;
    sh_load             = 1'b0;
    sh_step             = 1'b0;
    out_valid_next      = 1'b0;
    out_wen_next        = 1'b0;
    branch_taken_next   = 1'b0;
    out_op_type_next    = out_op_type_reg;
    out_rd_waddr_next   = out_rd_waddr_reg;
    out_result_next     = out_result_reg;
    out_store_data_next = out_store_data_reg;
    branch_target_next  = branch_target_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          out_valid_next    = 1'b1;
          out_op_type_next  = bus.op_type;
          out_rd_waddr_next = bus.rd_waddr;
          case (op_type_e'(bus.op_type))
            OPT_ALU: begin
              out_result_next = alu_result;
              out_wen_next    = rd_nonzero;
            end
            OPT_SHIFT: begin
`ifdef FWRISC_EXEC_FAST_SHIFT_EN
              out_result_next = sh_result;
              out_wen_next    = rd_nonzero;
`else
              if (sh_amount == 5'd0) begin
                out_result_next = bus.op_a;
                out_wen_next    = rd_nonzero;
              end else begin
                // Long shift: no result this cycle, bundle keeps its old contents.
                sh_load           = 1'b1;
                state_next        = ST_SHIFT;
                out_valid_next    = 1'b0;
                out_op_type_next  = out_op_type_reg;
                out_rd_waddr_next = out_rd_waddr_reg;
              end
`endif
            end
            OPT_BRANCH: begin
              branch_taken_next  = br_cond;
              branch_target_next = bus.op_c;
            end
            OPT_JUMP: begin
              out_result_next    = bus.op_a + (bus.instr_c ? XLEN'(2) : XLEN'(4));
              out_wen_next       = rd_nonzero;
              branch_taken_next  = 1'b1;
              branch_target_next = {bus.op_c[XLEN-1:1], 1'b0};
            end
            OPT_LDST: begin
              out_result_next     = bus.op_a + bus.op_c;
              out_store_data_next = bus.op_b;
            end
            default: begin
              // Unknown class retires as a bubble.
            end
          endcase
        end
      end
      ST_SHIFT: begin
`ifndef FWRISC_EXEC_FAST_SHIFT_EN
        sh_step = 1'b1;
        if (sh_last) begin
          state_next        = ST_IDLE;
          out_valid_next    = 1'b1;
          out_op_type_next  = OPT_SHIFT;
          out_rd_waddr_next = pend_rd_reg;
          out_result_next   = sh_result;
          out_wen_next      = (pend_rd_reg != '0);
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg          <= ST_IDLE;
      out_valid_reg      <= 1'b0;
      out_op_type_reg    <= '0;
      out_rd_waddr_reg   <= '0;
      out_wen_reg        <= 1'b0;
      out_result_reg     <= '0;
      out_store_data_reg <= '0;
      branch_taken_reg   <= 1'b0;
      branch_target_reg  <= '0;
    end else begin
      state_reg          <= state_next;
      out_valid_reg      <= out_valid_next;
      out_op_type_reg    <= out_op_type_next;
      out_rd_waddr_reg   <= out_rd_waddr_next;
      out_wen_reg        <= out_wen_next;
      out_result_reg     <= out_result_next;
      out_store_data_reg <= out_store_data_next;
      branch_taken_reg   <= branch_taken_next;
      branch_target_reg  <= branch_target_next;
    end
  end

  // Stall covers the accept cycle of a long shift and every SHIFT cycle.
  assign bus.stall          = sh_load | (state_reg == ST_SHIFT);
  assign bus.out_valid      = out_valid_reg;
  assign bus.out_op_type    = out_op_type_reg;
  assign bus.out_rd_waddr   = out_rd_waddr_reg;
  assign bus.out_wen        = out_wen_reg;
  assign bus.out_result     = out_result_reg;
  assign bus.out_store_data = out_store_data_reg;
  assign bus.branch_taken   = branch_taken_reg;
  assign bus.branch_target  = branch_target_reg;

endmodule

// File: tb/tb_fwrisc_exec_stage.sv
// tb_fwrisc_exec_stage
// Directed-vector bench for fwrisc_exec_stage. Each issued instruction pushes
// its hand-computed result bundle and expected arrival cycle into a scoreboard;
// a monitor on the falling edge pops and compares whenever out_valid is seen.
module tb_fwrisc_exec_stage;
  import fwrisc_exec_pkg::*;

  logic clock;
  logic reset;
  logic flush;
  int   checks;
  int   errors;
  int   cyc;
  int   txn_id;
  int   cyc0;
  logic stall0;
  bit   mon_en;

  fwrisc_exec_if #(.XLEN(32), .RADDR_W(6)) bus ();

  fwrisc_exec_stage #(.XLEN(32), .RADDR_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          id;
    int          cycle;
    logic [4:0]  op_type;
    logic [5:0]  rd;
    logic        wen;
    logic [31:0] res;
    bit          c_res;
    logic [31:0] st;
    bit          c_st;
    logic        bt;
    logic [31:0] tgt;
    bit          c_tgt;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each presented result against the oldest expectation.
  always @(negedge clock) begin
    if (mon_en && !reset && !flush) begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn %0d cycle=%0d op_type=%0d rd=%0d wen=%b result=%h store=%h taken=%b target=%h",
                   e.id, cyc, bus.out_op_type, bus.out_rd_waddr, bus.out_wen,
                   bus.out_result, bus.out_store_data, bus.branch_taken, bus.branch_target);
          chk($sformatf("txn%0d arrival_cycle", e.id), cyc, e.cycle);
          chk($sformatf("txn%0d op_type", e.id), 32'(bus.out_op_type), 32'(e.op_type));
          chk($sformatf("txn%0d rd", e.id), 32'(bus.out_rd_waddr), 32'(e.rd));
          chk($sformatf("txn%0d wen", e.id), 32'(bus.out_wen), 32'(e.wen));
          chk($sformatf("txn%0d taken", e.id), 32'(bus.branch_taken), 32'(e.bt));
          if (e.c_res) chk($sformatf("txn%0d result", e.id), bus.out_result, e.res);
          if (e.c_st)  chk($sformatf("txn%0d store_data", e.id), bus.out_store_data, e.st);
          if (e.c_tgt) chk($sformatf("txn%0d target", e.id), bus.branch_target, e.tgt);
        end
      end else begin
        chk("idle_wen", 32'(bus.out_wen), 32'd0);
        chk("idle_taken", 32'(bus.branch_taken), 32'd0);
      end
    end
  end

  // Called on a falling edge: present an instruction, note cycle-0 stall.
  task automatic drive(input logic [4:0] t, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic ic, input logic [5:0] rd);
    bus.op_type  = t;
    bus.op       = o;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_c     = c;
    bus.instr_c  = ic;
    bus.rd_waddr = rd;
    bus.in_valid = 1'b1;
    #1;
    stall0 = bus.stall;
    cyc0   = cyc;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] t, input logic [3:0] o,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic ic, input logic [5:0] rd,
                      input int lat, input int exp_stall,
                      input logic e_wen, input logic [31:0] e_res, input bit c_res,
                      input logic [31:0] e_st, input bit c_st,
                      input logic e_bt, input logic [31:0] e_tgt, input bit c_tgt);
    exp_t e;
    int   n;
    txn_id++;
    e.id = txn_id; e.op_type = t; e.rd = rd; e.wen = e_wen;
    e.res = e_res; e.c_res = c_res; e.st = e_st; e.c_st = c_st;
    e.bt = e_bt; e.tgt = e_tgt; e.c_tgt = c_tgt;
    e.cycle = cyc + lat;
    sb.push_back(e);
    drive(t, o, a, b, c, ic, rd);
    n = stall0 ? 1 : 0;
    for (int g = 0; g < 64 && bus.stall === 1'b1; g++) begin
      n++;
      @(negedge clock);
    end
    chk($sformatf("txn%0d stall_cycles", txn_id), n, exp_stall);
  endtask

  // Long shift interrupted at cycle 10 by flush (use_reset=0) or reset (1).
  task automatic abort_shift(input bit use_reset);
    drive(OPT_SHIFT, SH_SLL, 32'h0000_0001, 32'd31, 32'd0, 1'b0, 6'd10);
    chk("abort cycle0_stall", 32'(stall0), 32'd1);
    repeat (9) @(negedge clock);
    chk("abort cycle10_stall", 32'(bus.stall), 32'd1);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    flush = 1'b0;
    chk("abort cycle11_stall", 32'(bus.stall), 32'd0);
    if (use_reset) begin
      chk("reset out_result", bus.out_result, 32'd0);
      chk("reset out_store_data", bus.out_store_data, 32'd0);
      chk("reset out_rd", 32'(bus.out_rd_waddr), 32'd0);
      chk("reset out_op_type", 32'(bus.out_op_type), 32'd0);
      chk("reset branch_target", bus.branch_target, 32'd0);
    end
    // Any out_valid from the aborted shift would hit an empty scoreboard.
    repeat (40) @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; txn_id = 0; mon_en = 1'b0;
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.instr_c = 1'b0; bus.op = '0; bus.op_type = '0;
    bus.op_a = '0; bus.op_b = '0; bus.op_c = '0; bus.rd_waddr = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset out_result", bus.out_result, 32'd0);
    chk("reset out_wen", 32'(bus.out_wen), 32'd0);
    mon_en = 1'b1;

    //   type        op         op_a          op_b          op_c          ic  rd   lat st  wen res           cr st            cs bt tgt          ct
    send(OPT_ALU,    ALU_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  5,   1,  0,  1,  32'h00000000, 1, 0,            0, 0, 0,           0);
    send(OPT_ALU,    ALU_SUB,   32'h00000005, 32'h00000007, 32'h0,        0,  6,   1,  0,  1,  32'hFFFFFFFE, 1, 0,            0, 0, 0,           0);
    send(OPT_ALU,    ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  6,   1,  0,  1,  32'h00000001, 1, 0,            0, 0, 0,           0);
    send(OPT_ALU,    ALU_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  6,   1,  0,  1,  32'h00000000, 1, 0,            0, 0, 0,           0);
    send(OPT_SHIFT,  SH_SRA,    32'h80000000, 32'h00000004, 32'h0,        0,  7,   5,  5,  1,  32'hF8000000, 1, 0,            0, 0, 0,           0);
    send(OPT_ALU,    ALU_ADD,   32'h00000001, 32'h00000002, 32'h0,        0,  3,   1,  0,  1,  32'h00000003, 1, 0,            0, 0, 0,           0);
    send(OPT_SHIFT,  SH_SLL,    32'h00001234, 32'h00000020, 32'h0,        0,  8,   1,  0,  1,  32'h00001234, 1, 0,            0, 0, 0,           0);
    send(OPT_SHIFT,  SH_SRL,    32'h80000000, 32'h0000001F, 32'h0,        0,  9,   32, 32, 1,  32'h00000001, 1, 0,            0, 0, 0,           0);
    send(OPT_BRANCH, BR_LT,     32'hFFFFFFFF, 32'h00000001, 32'h00000100, 0,  3,   1,  0,  0,  32'h0,        0, 0,            0, 1, 32'h100,     1);
    send(OPT_BRANCH, BR_LTU,    32'hFFFFFFFF, 32'h00000001, 32'h00000100, 0,  3,   1,  0,  0,  32'h0,        0, 0,            0, 0, 32'h100,     1);
    send(OPT_JUMP,   4'd0,      32'h00000200, 32'h0,        32'h00000401, 1,  1,   1,  0,  1,  32'h00000202, 1, 0,            0, 1, 32'h400,     1);
    send(OPT_ALU,    ALU_ADD,   32'h00000007, 32'h00000008, 32'h0,        0,  0,   1,  0,  0,  32'h0000000F, 1, 0,            0, 0, 0,           0);
    send(OPT_LDST,   4'd0,      32'h00001000, 32'hDEADBEEF, 32'hFFFFFFFC, 0,  2,   1,  0,  0,  32'h00000FFC, 1, 32'hDEADBEEF, 1, 0, 0,           0);
    send(5'd9,       4'd0,      32'h00000011, 32'h00000022, 32'h0,        0,  4,   1,  0,  0,  32'h0,        0, 0,            0, 0, 0,           0);

    abort_shift(1'b0);
    send(OPT_ALU,    ALU_ADD,   32'h00000002, 32'h00000003, 32'h0,        0,  4,   1,  0,  1,  32'h00000005, 1, 0,            0, 0, 0,           0);
    abort_shift(1'b1);
    send(OPT_ALU,    ALU_ADD,   32'h0000000A, 32'h00000014, 32'h0,        0,  9,   1,  0,  1,  32'h0000001E, 1, 0,            0, 0, 0,           0);

    for (int g = 0; g < 100 && sb.size() != 0; g++) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
